// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: synchroniser, shared tick prescaler, per-channel stability counters.
// Define DEBOUNCE_MULTI_EDGE_EN to build the rise_out/fall_out pulse flops; otherwise those outputs tie to 0.
module debounce_multi #(
  parameter int SW_WIDTH      = 8,
  parameter int CLK_CNT_WIDTH = 24,
  parameter int STABLE_CNT    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CLK_CNT_WIDTH-1:0] div,
  input  logic [SW_WIDTH-1:0]      sw_in,
  output logic [SW_WIDTH-1:0]      sw_out,
  output logic [SW_WIDTH-1:0]      rise_out,
  output logic [SW_WIDTH-1:0]      fall_out,
  output logic                     tick_out
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  logic [SW_WIDTH-1:0]      r_sync [SYNC_STAGES];
  logic [SW_WIDTH-1:0]      w_sync;
  logic [CLK_CNT_WIDTH-1:0] r_cnt;
  logic [CLK_CNT_WIDTH-1:0] w_lim;
  logic                     w_wrap;
  logic                     r_tick;
  logic [SW_WIDTH-1:0]      w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // ">=" rather than "==" so a div lowered below the running count wraps at once.
  assign w_lim  = (div <= CLK_CNT_WIDTH'(1)) ? '0 : div - CLK_CNT_WIDTH'(1);
  assign w_wrap = (r_cnt >= w_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CLK_CNT_WIDTH'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick_out = r_tick;

  genvar gi;
  generate
    for (gi = 0; gi < SW_WIDTH; gi++) begin : g_ch
      logic [CW-1:0] r_stab;
      logic          r_level;
      logic          w_diff;

      assign w_diff       = w_sync[gi] ^ r_level;
      assign w_accept[gi] = w_diff & r_tick & (r_stab == LAST);
      assign sw_out[gi]   = r_level;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stab  <= '0;
          r_level <= 1'b0;
        end else if (!w_diff) begin
          r_stab <= '0;
        end else if (r_tick) begin
          if (r_stab == LAST) begin
            r_stab  <= '0;
            r_level <= w_sync[gi];
          end else begin
            r_stab <= r_stab + CW'(1);
          end
        end
      end

`ifdef DEBOUNCE_MULTI_EDGE_EN
      logic r_rise;
      logic r_fall;

      // Registered alongside r_level so the pulse lines up with the new level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= w_accept[gi] & w_sync[gi];
          r_fall <= w_accept[gi] & ~w_sync[gi];
        end
      end

      assign rise_out[gi] = r_rise;
      assign fall_out[gi] = r_fall;
`endif
    end
  endgenerate

`ifndef DEBOUNCE_MULTI_EDGE_EN
  assign rise_out = '0;
  assign fall_out = '0;
`endif

endmodule
